// File: rtl/clock_ctrl_fsm.sv
// Front-panel controller for the BCD time-of-day counter: button debounce, mode FSM, run prescaler.
// Define AUTO_REPEAT_EN to enable auto-repeat of the set button in SET_HR/SET_MIN.

module clock_ctrl_deb #(
    parameter logic [19:0] DEB_CYCLES = 20'd500000
) (
    input  logic clk,
    input  logic clr,
    input  logic raw,
    output logic level
);
    logic        s1, s2;
    logic [19:0] cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 != level) begin
                if (cnt == DEB_CYCLES - 20'd1) begin
                    level <= s2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 20'd1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module clock_ctrl_fsm #(
    parameter logic [19:0] DEB_CYCLES = 20'd500000,
    parameter logic [23:0] TICK_DIV   = 24'd500000,
    parameter logic [24:0] REPEAT_DLY = 25'd25000000,
    parameter logic [24:0] REPEAT_PER = 25'd5000000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn_run,
    input  logic       btn_mode,
    input  logic       btn_set,
    input  logic       btn_clr,
    output logic       start,
    output logic       clk_clr,
    output logic       addhr,
    output logic       addmin,
    output logic [1:0] mode
);
    typedef enum logic [1:0] {
        ST_STOP    = 2'b00,
        ST_RUN     = 2'b01,
        ST_SET_HR  = 2'b10,
        ST_SET_MIN = 2'b11
    } state_t;

    localparam int B_RUN  = 0;
    localparam int B_MODE = 1;
    localparam int B_SET  = 2;
    localparam int B_CLR  = 3;

    logic [3:0]  raw, lvl, lvl_d, press;
    state_t      state, state_nx;
    logic [23:0] pcnt, pcnt_nx;
    logic        start_nx, clr_nx, hr_nx, min_nx;
    logic        rep_fire;

    assign raw  = {btn_clr, btn_set, btn_mode, btn_run};
    assign mode = state;

    for (genvar i = 0; i < 4; i++) begin : g_deb
        clock_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk  (clk),
            .clr  (clr),
            .raw  (raw[i]),
            .level(lvl[i])
        );
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            lvl_d <= '0;
            press <= '0;
        end else begin
            lvl_d <= lvl;
            press <= lvl & ~lvl_d;
        end
    end

    // Priority inside each state: clr > run > mode > set.
    always_comb begin
        state_nx = state;
        pcnt_nx  = '0;
        start_nx = 1'b0;
        clr_nx   = 1'b0;
        hr_nx    = 1'b0;
        min_nx   = 1'b0;
        case (state)
            ST_STOP: begin
                if (press[B_CLR])       clr_nx   = 1'b1;
                else if (press[B_RUN])  state_nx = ST_RUN;
                else if (press[B_MODE]) state_nx = ST_SET_HR;
            end
            ST_RUN: begin
                if (press[B_RUN]) begin
                    state_nx = ST_STOP;
                end else if (pcnt == TICK_DIV - 24'd1) begin
                    start_nx = 1'b1;
                end else begin
                    pcnt_nx = pcnt + 24'd1;
                end
            end
            ST_SET_HR: begin
                if (press[B_CLR])                  clr_nx   = 1'b1;
                else if (press[B_RUN])             state_nx = ST_RUN;
                else if (press[B_MODE])            state_nx = ST_SET_MIN;
                else if (press[B_SET] || rep_fire) hr_nx    = 1'b1;
            end
            default: begin
                if (press[B_CLR])                  clr_nx   = 1'b1;
                else if (press[B_RUN])             state_nx = ST_RUN;
                else if (press[B_MODE])            state_nx = ST_STOP;
                else if (press[B_SET] || rep_fire) min_nx   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= ST_STOP;
            pcnt    <= '0;
            start   <= 1'b0;
            clk_clr <= 1'b0;
            addhr   <= 1'b0;
            addmin  <= 1'b0;
        end else begin
            state   <= state_nx;
            pcnt    <= pcnt_nx;
            start   <= start_nx;
            clk_clr <= clr_nx;
            addhr   <= hr_nx;
            addmin  <= min_nx;
        end
    end

`ifdef AUTO_REPEAT_EN
    logic        rep_on, rep_dly;
    logic [24:0] rep_cnt;

    // rep_dly selects the initial hold delay; after the first repeat the period applies.
    assign rep_fire = rep_on && lvl[B_SET] &&
                      (rep_dly ? (rep_cnt == REPEAT_DLY - 25'd1) : (rep_cnt == REPEAT_PER - 25'd1));

    always_ff @(posedge clk) begin
        if (clr) begin
            rep_on  <= 1'b0;
            rep_dly <= 1'b0;
            rep_cnt <= '0;
        end else if (hr_nx || min_nx) begin
            rep_on  <= 1'b1;
            rep_dly <= press[B_SET];
            rep_cnt <= '0;
        end else if (rep_on && lvl[B_SET] && state_nx == state && !clr_nx) begin
            rep_cnt <= rep_cnt + 25'd1;
        end else begin
            rep_on  <= 1'b0;
            rep_dly <= 1'b0;
            rep_cnt <= '0;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif
endmodule
